// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the 4-digit BCD 7-segment display path.
// Segment patterns are active-low and packed as {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam int N_DIGITS = 4;
    localparam int NIB_W    = 4;
    localparam int BCD_W    = N_DIGITS * NIB_W;
    localparam int SEG_W    = 7;

    typedef logic [BCD_W-1:0]    bcd_word_t;
    typedef logic [NIB_W-1:0]    nibble_t;
    typedef logic [SEG_W-1:0]    seg_t;
    typedef logic [N_DIGITS-1:0] anode_t;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

    localparam anode_t AN_OFF = 4'b1111;

    // Active-low one-hot anode enable for the given digit index.
    function automatic anode_t anode_sel(input logic [1:0] idx);
        anode_t onehot;
        onehot = anode_t'(1) << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble -> active-low 7-segment pattern.
// Nibbles 10..15 are not valid BCD and are shown as a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// 4-digit common-anode 7-segment scanner.
// The BCD word is copied into a shadow register only at frame boundaries, so a
// whole frame always shows one consistent value. Each digit slot ends with one
// all-anodes-off cycle so the previous digit's segments never ghost onto the
// next anode.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 3..1 (digit 0 is always shown).
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_dig_idx;
    bcd_word_t        r_shadow;
    seg_t             r_seg;
    anode_t           r_an;
    logic             r_frame_tick;

    logic             w_tick;
    logic             w_frame_end;
    nibble_t          w_digit [N_DIGITS];
    nibble_t          w_nibble;
    seg_t             w_seg_dec;
    logic [N_DIGITS-1:0] w_blank;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_tick && (r_dig_idx == 2'd3);

    // Split the shadow word into per-digit nibbles.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = r_shadow[gi*NIB_W +: NIB_W];
    end

    assign w_nibble = w_digit[r_dig_idx];

    seg7_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // an invalid nibble is non-zero, so it stops the blanking.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_lsd
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = (r_shadow[BCD_W-1:gi*NIB_W] == '0);
        end
    end
`else
    assign w_blank = '0;
`endif

    // Scan divider and digit index: advance one digit per SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dig_idx <= 2'd0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_dig_idx <= r_dig_idx + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Shadow capture of the BCD word, only on the last tick of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_frame_end && bcd_valid) begin
            r_shadow <= bcd;
        end
    end

    // Registered display outputs; the tick cycle forces all anodes off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_tick) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= anode_sel(r_dig_idx);
                r_seg <= w_blank[r_dig_idx] ? SEG_OFF : w_seg_dec;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
